id_reg_file_tagged: RTL and testbench
=====================================

# id_reg_file_tagged

Parametrised decode-stage register file with a per-register busy/tag scoreboard and multiple read ports. Successor to the single-read-port, modified-bit register file: each architectural register records whether a result is pending and which producer tag (ROB/RS index) will supply it. Writebacks clear busy only on a tag match. A flush clears all pending state. Sits in the ID stage between the decoder and the reservation stations; writeback comes from the CDB.

## Interface
- `DATA_WIDTH`, 32, register data width
- `REG_CNT`, 32, number of architectural registers; register 0 is hardwired zero
- `TAG_WIDTH`, 4, producer tag width
- `NUM_RD`, 2, number of read ports
- `AW` (localparam), $clog2(REG_CNT), register address width
- `CW` (localparam), $clog2(REG_CNT+1), busy-count width

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  asynchronous, active-low reset
- `rs_addr`  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
- `src_data`  out  NUM_RD*DATA_WIDTH  read data per port
- `src_busy`  out  NUM_RD  1 = value still pending for that port
- `src_tag`  out  NUM_RD*TAG_WIDTH  pending producer tag per port; 0 when not busy
- `issue_en`  in  1  decoder allocates a destination this cycle
- `issue_rd`  in  AW  destination register
- `issue_tag`  in  TAG_WIDTH  tag of the new producer
- `wb_en`  in  1  writeback valid
- `wb_rd`  in  AW  writeback register
- `wb_tag`  in  TAG_WIDTH  tag of the completing producer
- `wb_data`  in  DATA_WIDTH  result value
- `flush`  in  1  squash: clear all busy state
- `busy_cnt`  out  CW  number of registers currently busy

## Operation
- State per register i:
  - `regs[i]` (DATA_WIDTH)
  - `busy[i]` (1)
  - `tag[i]` (TAG_WIDTH)
- Reset (`rst`=0, async): all `regs`, `busy` and `tag` go to 0, and `busy_cnt` goes to 0. Outputs then read 0 / not busy / tag 0.
- Reads are combinational from current state:
  - `src_data[k]` = `regs[rs_addr[k]]`
  - `src_busy[k]` = `busy[rs_addr[k]]`
  - `src_tag[k]` = `busy ? tag : 0`
  - Address 0 always reads data 0, busy 0, tag 0.
- Issue (`issue_en`, `issue_rd`≠0): on the edge, `busy[issue_rd]`←1 and `tag[issue_rd]`←`issue_tag`. Re-issuing to an already-busy register overwrites the tag; the latest producer wins. Issue to register 0 is ignored.
- Writeback (`wb_en`, `wb_rd`≠0):
  - `regs[wb_rd]`←`wb_data` unconditionally.
  - `busy[wb_rd]`←0 only if `busy[wb_rd]` and `tag[wb_rd]`==`wb_tag`. A stale tag writes data but leaves busy set.
- Issue and writeback to the same register in the same cycle: data is written, and the issue's busy/tag takes effect. The register ends busy with `issue_tag`.
- Flush: on the edge all `busy` bits are cleared and all tags set to 0. Register data is kept, and a writeback in the same cycle still writes data. Flush overrides a same-cycle issue: no register ends busy.
- `busy_cnt` is a register equal to the popcount of `busy` after each edge. Maximum value is REG_CNT-1.

## Timing
- Read latency is 0 cycles, combinational from registered state.
- Issue and writeback effects are visible on reads in the cycle after the edge.
- `busy_cnt` reflects the same edge's updates, i.e. it is valid in the cycle after the edge.
- There is no backpressure; every request is accepted every cycle.
- Reset asserted mid-operation immediately clears all state, independent of `clk`.

## Configuration
- `ID_REG_FILE_WB_BYPASS_EN`
  - Defined: same-cycle writeback forwarding. If `wb_en` and `wb_rd`==`rs_addr[k]`≠0, then:
    - `src_data[k]`=`wb_data`.
    - If additionally `busy` is set and `tag`==`wb_tag`, then `src_busy[k]`=0 and `src_tag[k]`=0.
    - A same-cycle issue to that register does not affect the forwarded read.
  - Undefined: no forwarding; reads see the writeback one cycle later.

## Test plan
- Reset, then write back reg i with value i·3 for i=1..31 (tag 0, not busy). Next cycle every port reads i·3 with busy=0; reg 0 reads 0 after writeback of 0xFFFF_FFFF to it.
- Issue r5 tag 3 -> next cycle `src_busy`=1, `src_tag`=3, `busy_cnt`=1. Writeback r5 tag 2 data 7 -> data 7, still busy. Writeback r5 tag 3 data 9 -> data 9, busy=0, `busy_cnt`=0.
- Issue r8 tag 1, then issue r8 tag 4. Writeback r8 tag 1 leaves it busy with tag 4; writeback tag 4 clears it.
- Same cycle: issue r10 tag 6 plus writeback r10 tag 6 data 0x55 (r10 previously busy, tag 6) -> r10 = 0x55, busy, tag 6.
- Issue r1..r31 (tags i mod 16) -> `busy_cnt`=31. Then flush plus a same-cycle issue of r2 -> all busy=0, `busy_cnt`=0, data unchanged.
- With `ID_REG_FILE_WB_BYPASS_EN`: r3 busy tag 2, reads on both ports of r3 during writeback r3 tag 2 data 0xAB -> same cycle both ports return 0xAB with busy=0. Without the macro, the same cycle returns the old data with busy=1, and the next cycle returns 0xAB.
- Assert `rst` mid-sequence with 5 registers busy -> all outputs 0 immediately, `busy_cnt`=0.

Source files
------------

// File: rtl/id_reg_file_tagged.sv
// id_reg_file_tagged: decode-stage register file with per-register busy/tag scoreboard and NUM_RD read ports.
// Define ID_REG_FILE_WB_BYPASS_EN to forward a same-cycle writeback onto matching read ports.
module id_reg_file_tagged #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_CNT = 32,
  parameter int TAG_WIDTH = 4,
  parameter int NUM_RD = 2,
  localparam int AW = $clog2(REG_CNT),
  localparam int CW = $clog2(REG_CNT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*AW-1:0]         rs_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] src_data,
  output logic [NUM_RD-1:0]            src_busy,
  output logic [NUM_RD*TAG_WIDTH-1:0]  src_tag,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_rd,
  input  logic [TAG_WIDTH-1:0]         issue_tag,
  input  logic                         wb_en,
  input  logic [AW-1:0]                wb_rd,
  input  logic [TAG_WIDTH-1:0]         wb_tag,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         flush,
  output logic [CW-1:0]                busy_cnt
);
  logic [DATA_WIDTH-1:0] regs_q [REG_CNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_CNT];
  logic [TAG_WIDTH-1:0]  tag_q  [REG_CNT];
  logic [TAG_WIDTH-1:0]  tag_d  [REG_CNT];
  logic [REG_CNT-1:0]    busy_q, busy_d;
  logic [CW-1:0]         busy_cnt_q, busy_cnt_d;

  // Issue is applied after writeback so a same-cycle issue leaves the register busy; flush overrides both.
  always_comb begin
    regs_d = regs_q;
    tag_d = tag_q;
    busy_d = busy_q;
    busy_cnt_d = '0;
    if (wb_en && wb_rd != '0) begin
      regs_d[wb_rd] = wb_data;
      if (busy_q[wb_rd] && tag_q[wb_rd] == wb_tag) begin
        busy_d[wb_rd] = 1'b0;
        tag_d[wb_rd] = '0;
      end
    end
    if (issue_en && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd] = issue_tag;
    end
    if (flush) begin
      busy_d = '0;
      for (int i = 0; i < REG_CNT; i++) tag_d[i] = '0;
    end
    for (int i = 0; i < REG_CNT; i++) busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q <= tag_d;
      busy_q <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic nz, hit, clr;
    assign a = rs_addr[k*AW +: AW];
    assign nz = a != '0;
`ifdef ID_REG_FILE_WB_BYPASS_EN
    assign hit = wb_en && wb_rd == a && nz;
    assign clr = hit && busy_q[a] && tag_q[a] == wb_tag;
`else
    assign hit = 1'b0;
    assign clr = 1'b0;
`endif
    assign src_data[k*DATA_WIDTH +: DATA_WIDTH] = hit ? wb_data : (nz ? regs_q[a] : '0);
    assign src_busy[k] = nz && busy_q[a] && !clr;
    assign src_tag[k*TAG_WIDTH +: TAG_WIDTH] = (nz && busy_q[a] && !clr) ? tag_q[a] : '0;
  end
endmodule

// File: tb/tb_id_reg_file_tagged.sv
// tb_id_reg_file_tagged: directed self-checking bench for id_reg_file_tagged with default parameters.
module tb_id_reg_file_tagged;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [9:0] rs_addr = '0;
  logic [63:0] src_data;
  logic [1:0] src_busy;
  logic [7:0] src_tag;
  logic issue_en = 1'b0;
  logic [4:0] issue_rd = '0;
  logic [3:0] issue_tag = '0;
  logic wb_en = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [3:0] wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic flush = 1'b0;
  logic [5:0] busy_cnt;
  int checks = 0;
  int errors = 0;

  id_reg_file_tagged dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .src_data(src_data), .src_busy(src_busy),
    .src_tag(src_tag), .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_data(wb_data), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    wb_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue(input int r, input int t);
    issue_en = 1'b1; issue_rd = 5'(r); issue_tag = 4'(t);
  endtask

  task automatic wb(input int r, input int t, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = 5'(r); wb_tag = 4'(t); wb_data = d;
  endtask

  task automatic test_reset();
    rs_addr = {5'd7, 5'd1};
    #1;
    checks++; if (src_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", src_data); end
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", src_busy); end
    checks++; if (src_tag !== 8'h00) begin errors++; $display("FAIL reset_tag got %h exp 00", src_tag); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
    #5 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_writeback_all();
    for (int i = 1; i < 32; i++) begin
      wb(i, 0, 32'(i * 3));
      tick();
    end
    wb(0, 0, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 32; i++) begin
      rs_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++; if (src_data[31:0] !== 32'(i * 3)) begin errors++; $display("FAIL wb_all_p0 r%0d got %h exp %h", i, src_data[31:0], 32'(i * 3)); end
      checks++; if (src_data[63:32] !== 32'((31 - i) * 3)) begin errors++; $display("FAIL wb_all_p1 r%0d got %h exp %h", 31 - i, src_data[63:32], 32'((31 - i) * 3)); end
      checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL wb_all_busy r%0d got %b exp 00", i, src_busy); end
    end
  endtask

  task automatic test_issue_wb();
    rs_addr = {5'd0, 5'd5};
    issue(5, 3);
    tick();
    checks++; if (src_busy[0] !== 1'b1) begin errors++; $display("FAIL iss_busy got %b exp 1", src_busy[0]); end
    checks++; if (src_tag[3:0] !== 4'd3) begin errors++; $display("FAIL iss_tag got %0d exp 3", src_tag[3:0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL iss_cnt got %0d exp 1", busy_cnt); end
    checks++; if (src_busy[1] !== 1'b0 || src_tag[7:4] !== 4'd0) begin errors++; $display("FAIL iss_r0 got busy %b tag %0d exp 0 0", src_busy[1], src_tag[7:4]); end
    wb(5, 2, 32'd7);
    tick();
    checks++; if (src_data[31:0] !== 32'd7) begin errors++; $display("FAIL stale_data got %h exp 7", src_data[31:0]); end
    checks++; if (src_busy[0] !== 1'b1 || src_tag[3:0] !== 4'd3) begin errors++; $display("FAIL stale_busy got busy %b tag %0d exp 1 3", src_busy[0], src_tag[3:0]); end
    wb(5, 3, 32'd9);
    tick();
    checks++; if (src_data[31:0] !== 32'd9) begin errors++; $display("FAIL match_data got %h exp 9", src_data[31:0]); end
    checks++; if (src_busy[0] !== 1'b0 || src_tag[3:0] !== 4'd0) begin errors++; $display("FAIL match_busy got busy %b tag %0d exp 0 0", src_busy[0], src_tag[3:0]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL match_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_reissue();
    rs_addr = {5'd8, 5'd8};
    issue(8, 1);
    tick();
    issue(8, 4);
    tick();
    checks++; if (src_tag !== 8'h44 || busy_cnt !== 6'd1) begin errors++; $display("FAIL reiss_tag got %h cnt %0d exp 44 1", src_tag, busy_cnt); end
    wb(8, 1, 32'h11);
    tick();
    checks++; if (src_busy !== 2'b11 || src_tag[3:0] !== 4'd4 || src_data[31:0] !== 32'h11) begin errors++; $display("FAIL reiss_old got busy %b tag %0d data %h exp 11 4 11", src_busy, src_tag[3:0], src_data[31:0]); end
    wb(8, 4, 32'h44);
    tick();
    checks++; if (src_busy !== 2'b00 || busy_cnt !== 6'd0 || src_data[63:32] !== 32'h44) begin errors++; $display("FAIL reiss_new got busy %b cnt %0d data %h exp 00 0 44", src_busy, busy_cnt, src_data[63:32]); end
  endtask

  task automatic test_same_cycle();
    rs_addr = {5'd10, 5'd10};
    issue(10, 6);
    tick();
    issue(10, 6);
    wb(10, 6, 32'h55);
    tick();
    checks++; if (src_data[31:0] !== 32'h55) begin errors++; $display("FAIL same_data got %h exp 55", src_data[31:0]); end
    checks++; if (src_busy !== 2'b11 || src_tag !== 8'h66 || busy_cnt !== 6'd1) begin errors++; $display("FAIL same_busy got busy %b tag %h cnt %0d exp 11 66 1", src_busy, src_tag, busy_cnt); end
    wb(10, 6, 32'h55);
    tick();
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL same_clear got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_flush();
    for (int i = 1; i < 32; i++) begin
      issue(i, i % 16);
      tick();
    end
    rs_addr = {5'd31, 5'd17};
    #1;
    checks++; if (busy_cnt !== 6'd31) begin errors++; $display("FAIL full_cnt got %0d exp 31", busy_cnt); end
    checks++; if (src_tag !== 8'hF1 || src_busy !== 2'b11) begin errors++; $display("FAIL full_tag got %h busy %b exp f1 11", src_tag, src_busy); end
    flush = 1'b1;
    issue(2, 5);
    tick();
    rs_addr = {5'd31, 5'd2};
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", busy_cnt); end
    checks++; if (src_busy !== 2'b00 || src_tag !== 8'h00) begin errors++; $display("FAIL flush_busy got %b tag %h exp 00 00", src_busy, src_tag); end
    checks++; if (src_data !== {32'd93, 32'd6}) begin errors++; $display("FAIL flush_data got %h exp %h", src_data, {32'd93, 32'd6}); end
  endtask

  task automatic test_bypass();
    issue(3, 2);
    tick();
    rs_addr = {5'd3, 5'd3};
    wb(3, 2, 32'hAB);
    #1;
`ifdef ID_REG_FILE_WB_BYPASS_EN
    checks++; if (src_data !== {32'hAB, 32'hAB} || src_busy !== 2'b00 || src_tag !== 8'h00) begin errors++; $display("FAIL byp_same got %h busy %b tag %h exp ab/ab 00 00", src_data, src_busy, src_tag); end
`else
    checks++; if (src_data !== {32'd9, 32'd9} || src_busy !== 2'b11 || src_tag !== 8'h22) begin errors++; $display("FAIL nobyp_same got %h busy %b tag %h exp 9/9 11 22", src_data, src_busy, src_tag); end
`endif
    tick();
    checks++; if (src_data !== {32'hAB, 32'hAB} || src_busy !== 2'b00) begin errors++; $display("FAIL byp_next got %h busy %b exp ab/ab 00", src_data, src_busy); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) begin
      issue(i, i + 8);
      tick();
    end
    rs_addr = {5'd5, 5'd1};
    #1;
    checks++; if (busy_cnt !== 6'd5 || src_busy !== 2'b11) begin errors++; $display("FAIL pre_rst got cnt %0d busy %b exp 5 11", busy_cnt, src_busy); end
    #1 rst = 1'b0;
    #1;
    checks++; if (src_data !== 64'h0 || src_busy !== 2'b00 || src_tag !== 8'h00) begin errors++; $display("FAIL arst_out got %h busy %b tag %h exp 0 00 00", src_data, src_busy, src_tag); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", busy_cnt); end
    #3 rst = 1'b1;
    tick();
    checks++; if (busy_cnt !== 6'd0 || src_data !== 64'h0) begin errors++; $display("FAIL post_rst got cnt %0d data %h exp 0 0", busy_cnt, src_data); end
  endtask

  initial begin
    test_reset();
    test_writeback_all();
    test_issue_wb();
    test_reissue();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
